bcd_to_binary_seq: RTL and testbench

- Sequential BCD-to-binary converter using reverse double-dabble: shift right, then subtract 3 from each BCD nibble >= 8.
- Inverse of the combinational binary-to-BCD path that drives HEX0–HEX2.
- Converts decimal digits entered on SW (one nibble per digit) into a binary value for counter preload and arithmetic blocks.
- Start/done handshake; one shift per clock.

---
 rtl/bcd_to_binary_seq_if.sv | 38 +++
 rtl/bcd_to_binary_seq.sv | 168 ++++++++++++++++
 tb/tb_bcd_to_binary_seq.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/bcd_to_binary_seq_if.sv
// Handshake and data bundle for bcd_to_binary_seq.
//   start   : conversion request (sampled only while the converter is idle)
//   bcd_in  : packed BCD digits, digit 0 (ones) in bits [3:0]
//   bin_out : converted binary value, held until the next accepted start
//   busy    : high while converting and during the done cycle
//   done    : one-cycle pulse, bin_out/err valid
//   err     : set with done when any input nibble is above 9
interface bcd_to_binary_seq_if #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned W      = 10
) ();
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic [W-1:0]          bin_out;
    logic                  busy;
    logic                  done;
    logic                  err;

    // Requester side: issues start/bcd_in, observes the result.
    modport master (
        output start,
        output bcd_in,
        input  bin_out,
        input  busy,
        input  done,
        input  err
    );

    // Converter side.
    modport slave (
        input  start,
        input  bcd_in,
        output bin_out,
        output busy,
        output done,
        output err
    );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble).
// Each CONV cycle shifts {bcd, bin} right by one and then subtracts 3 from
// every BCD nibble that is >= 8; after W shifts the binary field holds the
// value and the BCD field has drained to zero.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : bcd_to_binary_seq_if.slave (start, bcd_in, bin_out, busy, done, err)
module bcd_to_binary_seq #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned W      = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_to_binary_seq_if.slave   bus
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned R_W   = BCD_W + W;
    localparam int unsigned CNT_W = $clog2(W + 1);

    // Largest decimal value representable with DIGITS digits.
    function automatic longint unsigned max_dec_f(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam longint unsigned MAX_DEC = max_dec_f(DIGITS);

    // The binary field must be wide enough for every valid decimal input.
    if (W < 64 && (64'd1 << W) <= MAX_DEC) begin : g_w_too_small
        $error("bcd_to_binary_seq: W too small for DIGITS");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [R_W-1:0]      r_q, r_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [W-1:0]        bin_q, bin_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [R_W-1:0]      r_shift_c;
    logic [R_W-1:0]      r_corr_c;
    logic                bcd_bad_c;
    logic                last_shift_c;

    // Any input nibble outside 0..9 is flagged as an error at acceptance.
    always_comb begin
        bcd_bad_c = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9) begin
                bcd_bad_c = 1'b1;
            end
        end
    end

    // One reverse double-dabble step: logical right shift, then per-nibble
    // correction of the BCD field applied to the shifted value.
    always_comb begin
        r_shift_c = r_q >> 1;
        r_corr_c  = r_shift_c;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (r_shift_c[W + 4*i +: 4] >= 4'd8) begin
                r_corr_c[W + 4*i +: 4] = r_shift_c[W + 4*i +: 4] - 4'd3;
            end
        end
    end

    assign last_shift_c = (cnt_q == CNT_W'(W - 1));

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    r_d    = {bus.bcd_in, {W{1'b0}}};
                    cnt_d  = '0;
                    err_d  = 1'b0;
                    busy_d = 1'b1;
                    if (bcd_bad_c) begin
                        // Invalid digit: skip conversion, report at once.
                        err_d   = 1'b1;
                        bin_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CONV;
                    end
                end
            end

            ST_CONV: begin
                busy_d = 1'b1;
                r_d    = r_corr_c;
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_shift_c) begin
                    bin_d   = r_corr_c[W-1:0];
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over everything, including
    // an in-flight conversion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.bin_out = bin_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

    // A valid input always drains the BCD field by the final shift.
    bcd_drained_a: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state_q == ST_CONV && last_shift_c) |-> (r_corr_c[R_W-1:W] == '0)
    );

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
module tb_bcd_to_binary_seq;

    localparam int unsigned DIGITS = 3;
    localparam int unsigned W      = 10;
    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int          LIMIT  = 40;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    bcd_to_binary_seq_if #(.DIGITS(DIGITS), .W(W)) bus ();

    bcd_to_binary_seq #(.DIGITS(DIGITS), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: decimal value of the digits, or error if any digit > 9.
    function automatic void ref_conv(input logic [BCD_W-1:0] bcd,
                                     output int unsigned val, output bit bad);
        int unsigned scale;
        int unsigned d;
        val   = 0;
        bad   = 1'b0;
        scale = 1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            d = int'(bcd[4*i +: 4]);
            if (d > 9) bad = 1'b1;
            val   = val + d * scale;
            scale = scale * 10;
        end
        if (bad) val = 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One conversion; optionally pulses start again at cycle inject_at while busy.
    task automatic do_conv(input logic [BCD_W-1:0] bcd, input int inject_at);
        int unsigned exp_val;
        bit          exp_bad;
        int          n;
        ref_conv(bcd, exp_val, exp_bad);
        bus.start  = 1'b1;
        bus.bcd_in = bcd;
        tick();
        bus.start  = 1'b0;
        bus.bcd_in = BCD_W'($urandom);
        n = 1;
        while (!bus.done && n < LIMIT) begin
            check_eq("busy_during", 32'(bus.busy), 32'd1);
            if (n == inject_at) begin
                bus.start  = 1'b1;
                bus.bcd_in = 12'h777;
            end
            tick();
            bus.start = 1'b0;
            n++;
        end
        check_eq("latency", 32'(n), exp_bad ? 32'd1 : 32'(W + 1));
        check_eq("done", 32'(bus.done), 32'd1);
        check_eq("busy_at_done", 32'(bus.busy), 32'd1);
        check_eq("bin_out", 32'(bus.bin_out), 32'(exp_val));
        check_eq("err", 32'(bus.err), 32'(exp_bad));
        tick();
        check_eq("done_pulse_end", 32'(bus.done), 32'd0);
        check_eq("busy_end", 32'(bus.busy), 32'd0);
        check_eq("bin_hold", 32'(bus.bin_out), 32'(exp_val));
    endtask

    initial begin
        logic [BCD_W-1:0] rnd;
        int               dones;
        int               last_done;
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.bcd_in  = '0;
        tick();
        tick();
        check_eq("rst_bin", 32'(bus.bin_out), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed values.
        do_conv(12'h255, 0);
        do_conv(12'h999, 0);
        do_conv(12'h000, 0);
        do_conv(12'h100, 0);
        do_conv(12'h1A3, 0);

        // Start while busy is ignored.
        do_conv(12'h042, 4);

        // Reset mid-conversion discards the result.
        bus.start  = 1'b1;
        bus.bcd_in = 12'h123;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("midrst_bin", 32'(bus.bin_out), 32'd0);
        check_eq("midrst_busy", 32'(bus.busy), 32'd0);
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.done) dones++;
            tick();
        end
        check_eq("midrst_no_done", 32'(dones), 32'd0);
        do_conv(12'h007, 0);

        // Random digits, mostly valid with an occasional bad nibble.
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                if ($urandom_range(99) < 90) rnd[4*i +: 4] = 4'($urandom_range(9));
                else                         rnd[4*i +: 4] = 4'($urandom_range(15, 10));
            end
            do_conv(rnd, (t % 3 == 0) ? int'($urandom_range(W, 1)) : 0);
        end

        // start held high: back-to-back conversions every W+2 cycles.
        bus.start  = 1'b1;
        bus.bcd_in = 12'h500;
        tick();
        dones     = 0;
        last_done = 0;
        for (int n = 1; n < 80 && dones < 4; n++) begin
            if (bus.done) begin
                check_eq("held_bin", 32'(bus.bin_out), 32'd500);
                check_eq("held_err", 32'(bus.err), 32'd0);
                if (dones == 0) check_eq("held_first", 32'(n), 32'(W + 1));
                else            check_eq("held_period", 32'(n - last_done), 32'(W + 2));
                last_done = n;
                dones++;
                if (dones == 4) bus.start = 1'b0;
            end
            tick();
        end
        bus.start = 1'b0;
        check_eq("held_count", 32'(dones), 32'd4);
        for (int i = 0; i < 3; i++) tick();
        check_eq("held_idle", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
